// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin 2:1 byte arbiter driving a CTSn-gated 8N1 UART transmitter.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_arb #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       uart_ctsn,
  output logic       uart_txd,
  output logic       busy,
  output logic       grant_id
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_ARB_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t        r_state;
  logic          r_cts_s1;
  logic          r_cts_s2;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit;
  logic          r_last;
  logic          r_grant;
  logic          r_txd;
  logic          r_busy;
`ifdef UART_TX_ARB_PARITY_EN
  logic          r_par;
`endif

  logic w_go;
  logic w_pick1;
  logic w_tick;

  // On a tie, the requester that did not win last time is served.
  assign w_pick1 = req1_valid && (!req0_valid || !r_last);
  assign w_go    = !rst && (r_state == S_IDLE) && !r_cts_s2
                   && (req0_valid || req1_valid);
  assign w_tick  = (r_cnt == '0);

  assign req0_ready = w_go && !w_pick1;
  assign req1_ready = w_go && w_pick1;
  assign uart_txd   = r_txd;
  assign busy       = r_busy;
  assign grant_id   = r_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cts_s1 <= 1'b1;
      r_cts_s2 <= 1'b1;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_bit    <= '0;
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_cts_s1 <= uart_ctsn;
      r_cts_s2 <= r_cts_s1;
      if (r_state != S_IDLE)
        r_cnt <= w_tick ? RELOAD : r_cnt - 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_shift <= w_pick1 ? req1_data : req0_data;
            r_grant <= w_pick1;
            r_last  <= w_pick1;
            r_cnt   <= RELOAD;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
`ifdef UART_TX_ARB_PARITY_EN
            r_par   <= w_pick1 ? ^req1_data : ^req0_data;
`endif
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state <= S_DATA;
            r_bit   <= '0;
            r_txd   <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
              r_state <= S_PARITY;
              r_txd   <= r_par;
`else
              r_state <= S_STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_ARB_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb at CLKS_PER_BIT=4.
// A serial monitor decodes frames off uart_txd and matches them to queued expectations.
module tb_uart_tx_arb;

  localparam int N = 4;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req0_data = '0;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [7:0] req1_data = '0;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic       uart_ctsn = 1'b1;
  logic       uart_txd;
  logic       busy;
  logic       grant_id;

  uart_tx_arb #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .uart_ctsn  (uart_ctsn),
    .uart_txd   (uart_txd),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       gid;
    logic [7:0] data;
    logic       par;
  } exp_t;

  typedef struct packed {
    logic       gid;
    logic [7:0] data;
    logic       par;
    logic       start;
    logic       stop;
  } rx_t;

  exp_t exp_q[$];
  rx_t  rx_q[$];

  function automatic exp_t mk_exp(input logic g, input logic [7:0] d);
    exp_t e;
    e.gid  = g;
    e.data = d;
    e.par  = (FB == 11) ? ^d : 1'b0;
    return e;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9 && FB == 11) return ^d;
    return 1'b1;
  endfunction

  // Serial receiver: samples each bit mid-cell, aborts on reset.
  initial begin
    bit  act;
    int  k;
    int  b;
    rx_t r;
    act = 1'b0;
    k = 0;
    b = 0;
    r = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
      end else begin
        if (!act && uart_txd === 1'b0) begin
          act = 1'b1;
          k = 0;
          r = '0;
          r.gid = grant_id;
        end
        if (act) begin
          if (k % N == N / 2) begin
            b = k / N;
            if (b == 0) r.start = uart_txd;
            else if (b <= 8) r.data[b-1] = uart_txd;
            else if (b == FB - 1) begin
              r.stop = uart_txd;
              rx_q.push_back(r);
              act = 1'b0;
            end else r.par = uart_txd;
          end
          k++;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    uart_ctsn = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_accept(input int lim, output bit ok, output logic gid);
    ok = 1'b0;
    gid = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        ok = 1'b1;
        gid = req1_ready;
        return;
      end
    end
  endtask

  task automatic wait_frames();
    for (int i = 0; i < 12 * FB * N && rx_q.size() < exp_q.size(); i++)
      @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    req0_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({uart_txd, busy, grant_id, req0_ready, req1_ready} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset: txd,busy,gid,rdy0,rdy1 = %b, want 10000",
               {uart_txd, busy, grant_id, req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_single();
    bit ok; logic g; int pulses; int bsy; exp_t e; rx_t r;
    do_reset();
    uart_ctsn = 1'b0;
    req0_data = 8'hA5;
    req0_valid = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 8'hA5));
    wait_accept(10, ok, g);
    n_vec++;
    if (!ok || g !== 1'b0) begin
      n_err++;
      $display("FAIL single_accept: ok=%0d gid=%b, want 1/0", ok, g);
    end
    pulses = 1;
    bsy = 0;
    @(posedge clk); #1 req0_valid = 1'b0;
    for (int i = 0; i < FB * N; i++) begin
      @(negedge clk);
      n_vec++;
      if (uart_txd !== frame_bit(8'hA5, i / N)) begin
        n_err++;
        $display("FAIL single_txd cycle %0d: got %b want %b",
                 i, uart_txd, frame_bit(8'hA5, i / N));
      end
      if (busy === 1'b1) bsy++;
      if (req0_ready === 1'b1) pulses++;
    end
    @(negedge clk);
    n_vec++;
    if (bsy != FB * N || busy !== 1'b0 || pulses != 1) begin
      n_err++;
      $display("FAIL single_busy: busy cycles %0d (end %b) pulses %0d, want %0d/0/1",
               bsy, busy, pulses, FB * N);
    end
    wait_frames();
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL single_count: got %0d frames want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); n_vec++;
      if ({r.gid, r.data, r.par, r.start, r.stop} !== {e.gid, e.data, e.par, 2'b01}) begin
        n_err++;
        $display("FAIL single_frame: got g%b %h p%b, want g%b %h p%b",
                 r.gid, r.data, r.par, e.gid, e.data, e.par);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok; logic g; logic mlast; logic eg; int tprev; exp_t e; rx_t r;
    do_reset();
    uart_ctsn = 1'b0;
    req0_data = 8'h11;
    req1_data = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    mlast = 1'b1;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      eg = ~mlast;
      mlast = eg;
      exp_q.push_back(mk_exp(eg, eg ? 8'h22 : 8'h11));
      wait_accept(FB * N + 10, ok, g);
      n_vec++;
      if (!ok || g !== eg) begin
        n_err++;
        $display("FAIL rr_grant %0d: ok=%0d gid=%b want %b", k, ok, g, eg);
      end
      if (k > 0) begin
        n_vec++;
        if (cyc - tprev != FB * N + 1) begin
          n_err++;
          $display("FAIL rr_spacing %0d: got %0d want %0d", k, cyc - tprev, FB * N + 1);
        end
      end
      tprev = cyc;
      @(posedge clk); #1;
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      n_vec++;
      if (grant_id !== eg) begin
        n_err++;
        $display("FAIL rr_grant_id %0d: got %b want %b", k, grant_id, eg);
      end
    end
    wait_frames();
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rr_count: got %0d frames want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); n_vec++;
      if ({r.gid, r.data, r.par, r.start, r.stop} !== {e.gid, e.data, e.par, 2'b01}) begin
        n_err++;
        $display("FAIL rr_frame: got g%b %h p%b, want g%b %h p%b",
                 r.gid, r.data, r.par, e.gid, e.data, e.par);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_cts();
    bit ok; logic g; int c; exp_t e; rx_t r;
    do_reset();
    req1_data = 8'h3C;
    req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || uart_txd !== 1'b1) begin
        n_err++;
        $display("FAIL cts_hold %0d: rdy=%b%b txd=%b want 00/1",
                 i, req0_ready, req1_ready, uart_txd);
      end
    end
    @(posedge clk); #1 uart_ctsn = 1'b0;
    c = cyc;
    exp_q.push_back(mk_exp(1'b1, 8'h3C));
    wait_accept(10, ok, g);
    n_vec++;
    if (!ok || g !== 1'b1 || cyc != c + 2) begin
      n_err++;
      $display("FAIL cts_latency: ok=%0d gid=%b at C+%0d, want 1/1/C+2", ok, g, cyc - c);
    end
    @(posedge clk); #1 req1_data = 8'h5A;
    repeat (8) @(posedge clk);
    #1 uart_ctsn = 1'b1;
    for (int i = 0; i < 4 * FB * N && busy !== 1'b0; i++) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_vec++;
      if (req1_ready !== 1'b0 || busy !== 1'b0 || uart_txd !== 1'b1) begin
        n_err++;
        $display("FAIL cts_block %0d: rdy1=%b busy=%b txd=%b want 0/0/1",
                 i, req1_ready, busy, uart_txd);
      end
    end
    @(posedge clk); #1 uart_ctsn = 1'b0;
    exp_q.push_back(mk_exp(1'b1, 8'h5A));
    wait_accept(10, ok, g);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL cts_resume: no accept, want accept");
    end
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_frames();
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL cts_count: got %0d frames want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); n_vec++;
      if ({r.gid, r.data, r.par, r.start, r.stop} !== {e.gid, e.data, e.par, 2'b01}) begin
        n_err++;
        $display("FAIL cts_frame: got g%b %h p%b, want g%b %h p%b",
                 r.gid, r.data, r.par, e.gid, e.data, e.par);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok; logic g; exp_t e; rx_t r;
    do_reset();
    uart_ctsn = 1'b0;
    req0_data = 8'hC3;
    req0_valid = 1'b1;
    wait_accept(10, ok, g);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL rmid_accept: no accept, want accept");
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    // Cycle T+18 lies inside data bit 3 (T+17..T+20).
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    req0_data = 8'h96;
    req0_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_rst_cycle: rdy=%b%b want 00", req0_ready, req1_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({uart_txd, busy, req0_ready, req1_ready} !== 4'b1000) begin
      n_err++;
      $display("FAIL rmid_after: txd,busy,rdy0,rdy1 = %b want 1000",
               {uart_txd, busy, req0_ready, req1_ready});
    end
    exp_q.push_back(mk_exp(1'b0, 8'h96));
    wait_accept(10, ok, g);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_frames();
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rmid_count: got %0d frames want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); n_vec++;
      if ({r.gid, r.data, r.par, r.start, r.stop} !== {e.gid, e.data, e.par, 2'b01}) begin
        n_err++;
        $display("FAIL rmid_frame: got g%b %h p%b, want g%b %h p%b",
                 r.gid, r.data, r.par, e.gid, e.data, e.par);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_busy_pulse();
    bit ok; logic g; int bad; exp_t e; rx_t r;
    do_reset();
    uart_ctsn = 1'b0;
    req1_data = 8'h81;
    req1_valid = 1'b1;
    exp_q.push_back(mk_exp(1'b1, 8'h81));
    wait_accept(10, ok, g);
    @(posedge clk); #1 req1_valid = 1'b0;
    bad = 0;
    for (int i = 1; i <= FB * N; i++) begin
      req0_data = 8'h42;
      req0_valid = (i == 5);
      req1_valid = (i == 20);
      @(negedge clk);
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL busy_ready: %0d cycles with ready high, want 0", bad);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_pulse_idle: busy=%b want 0", busy);
    end
    wait_frames();
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL busy_count: got %0d frames want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); n_vec++;
      if ({r.gid, r.data, r.par, r.start, r.stop} !== {e.gid, e.data, e.par, 2'b01}) begin
        n_err++;
        $display("FAIL busy_frame: got g%b %h p%b, want g%b %h p%b",
                 r.gid, r.data, r.par, e.gid, e.data, e.par);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

`ifdef UART_TX_ARB_PARITY_EN
  task automatic test_parity();
    bit ok; logic g; int bsy; exp_t e; rx_t r;
    do_reset();
    uart_ctsn = 1'b0;
    req0_data = 8'h07;
    req0_valid = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 8'h07));
    wait_accept(10, ok, g);
    @(posedge clk); #1 req0_valid = 1'b0;
    bsy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bsy++;
    end
    n_vec++;
    if (bsy != 44) begin
      n_err++;
      $display("FAIL parity_len: busy cycles %0d want 44", bsy);
    end
    wait_frames();
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); n_vec++;
      if ({r.data, r.par, r.stop} !== {e.data, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL parity_frame: got %h p%b s%b, want %h p1 s1",
                 r.data, r.par, r.stop, e.data);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_cts();
    test_reset_mid();
    test_busy_pulse();
`ifdef UART_TX_ARB_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
